// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one variable-latency memory, with round-robin or fixed priority and access timeout
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter int CORE_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic id_q, id_d, we_q, we_d, last_q, last_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic win, fin;
  always_comb begin
    win = (req0 && req1) ? ((CORE_PRIORITY != 0) ? 1'b0 : ~last_q) : req1;
    fin = mem_ready || (cnt_q == CW'(TIMEOUT - 1));
    state_d = state_q;
    id_d = id_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    last_d = last_q;
    err_d = err_q;
    cnt_d = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: if (req0 || req1) begin
        gnt0 = ~win;
        gnt1 = win;
        id_d = win;
        we_d = win ? we1 : we0;
        addr_d = win ? addr1 : addr0;
        wdata_d = win ? wdata1 : wdata0;
        cnt_d = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (fin) begin
          err_d = ~mem_ready;
          rdata0_d = id_q ? rdata0_q : ((mem_ready && !we_q) ? mem_rdata : '0);
          rdata1_d = id_q ? ((mem_ready && !we_q) ? mem_rdata : '0) : rdata1_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d = id_q;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      last_q <= 1'b1;
      err_q <= 1'b0;
      cnt_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      last_q <= last_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign mem_en = state_q == ACCESS;
  assign mem_we = mem_en && we_q;
  assign mem_addr = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign done0 = state_q == DONE && !id_q;
  assign done1 = state_q == DONE && id_q;
  assign err0 = done0 && err_q;
  assign err1 = done1 && err_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter in round-robin and core-priority builds
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ready = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic p_gnt0, p_gnt1, p_done0, p_done1, p_err0, p_err1, p_mem_en, p_mem_we;
  logic [31:0] p_rdata0, p_rdata1, p_mem_addr, p_mem_wdata;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.CORE_PRIORITY(0)) u0 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  mem_arbiter #(.CORE_PRIORITY(1)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1), .err0(p_err0), .err1(p_err1),
    .rdata0(p_rdata0), .rdata1(p_rdata1), .mem_en(p_mem_en), .mem_we(p_mem_we),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    @(negedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_p_mem_en", 32'(p_mem_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h10; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    chk("rd_gnt1", 32'(gnt1), 32'd0);
    chk("rd_idle_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_mem_en", 32'(mem_en), 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    req0 = 0;
    #1;
    chk("rd_done0", 32'(done0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_err0", 32'(err0), 32'd0);
    chk("rd_done1", 32'(done1), 32'd0);
    chk("rd_done_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_after_done0", 32'(done0), 32'd0);
    chk("rd_after_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1; req1 = 1; mem_ready = 1; mem_rdata = 32'h100 + 32'(i);
      #1;
      chk("rr_gnt0", 32'(gnt0), 32'(i % 2 == 0));
      chk("rr_gnt1", 32'(gnt1), 32'(i % 2 == 1));
      chk("prio_gnt0", 32'(p_gnt0), 32'd1);
      chk("prio_gnt1", 32'(p_gnt1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      if (i == 3) begin
        req0 = 0; req1 = 0;
      end
      #1;
      chk("rr_done0", 32'(done0), 32'(i % 2 == 0));
      chk("rr_done1", 32'(done1), 32'(i % 2 == 1));
      chk("rr_rdata", (i % 2 == 0) ? rdata0 : rdata1, 32'h100 + 32'(i));
      chk("prio_done0", 32'(p_done0), 32'd1);
      chk("prio_rdata0", p_rdata0, 32'h100 + 32'(i));
    end
    @(negedge clk);
    mem_ready = 0; req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h1234;
    #1;
    chk("wr_gnt1", 32'(gnt1), 32'd1);
    chk("wr_gnt0", 32'(gnt0), 32'd0);
    chk("wr_p_gnt1", 32'(p_gnt1), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr1 = 32'h99; wdata1 = 32'h0;
      end
      if (k == 6) mem_ready = 1;
      #1;
      chk("wr_mem_en", 32'(mem_en), 32'd1);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_addr", mem_addr, 32'h40);
      chk("wr_mem_wdata", mem_wdata, 32'h1234);
      chk("wr_early_done1", 32'(done1), 32'd0);
    end
    @(negedge clk);
    req1 = 0; we1 = 0; mem_ready = 0;
    #1;
    chk("wr_done1", 32'(done1), 32'd1);
    chk("wr_err1", 32'(err1), 32'd0);
    chk("wr_rdata1", rdata1, 32'd0);
    chk("wr_done0", 32'(done0), 32'd0);
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h20; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("to_gnt0", 32'(gnt0), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      chk("to_mem_en", 32'(mem_en), 32'd1);
      chk("to_early_done0", 32'(done0), 32'd0);
    end
    @(negedge clk);
    req0 = 0;
    #1;
    chk("to_mem_en_off", 32'(mem_en), 32'd0);
    chk("to_done0", 32'(done0), 32'd1);
    chk("to_err0", 32'(err0), 32'd1);
    chk("to_rdata0", rdata0, 32'd0);
    @(negedge clk);
    #1;
    chk("to_idle_done0", 32'(done0), 32'd0);
    chk("to_idle_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    req0 = 1; mem_rdata = 32'hA5A55A5A;
    #1;
    chk("lr_gnt0", 32'(gnt0), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) mem_ready = 1;
      #1;
      if (k == 16) chk("lr_mem_en", 32'(mem_en), 32'd1);
    end
    @(negedge clk);
    req0 = 0; mem_ready = 0;
    #1;
    chk("lr_done0", 32'(done0), 32'd1);
    chk("lr_err0", 32'(err0), 32'd0);
    chk("lr_rdata0", rdata0, 32'hA5A55A5A);
    @(negedge clk);
    req0 = 1;
    #1;
    chk("ra_gnt0", 32'(gnt0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ra_mem_en_before", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("ra_mem_en_async", 32'(mem_en), 32'd0);
    chk("ra_p_mem_en_async", 32'(p_mem_en), 32'd0);
    @(negedge clk);
    #1;
    chk("ra_no_done0", 32'(done0), 32'd0);
    chk("ra_no_done1", 32'(done1), 32'd0);
    @(negedge clk);
    rst = 1'b0; req1 = 1;
    #1;
    chk("ra_gnt0_first", 32'(gnt0), 32'd1);
    chk("ra_gnt1_first", 32'(gnt1), 32'd0);
    @(negedge clk);
    mem_ready = 1;
    @(negedge clk);
    req0 = 0;
    #1;
    chk("ra_done0", 32'(done0), 32'd1);
    @(negedge clk);
    #1;
    chk("ra_rearb_gnt1", 32'(gnt1), 32'd1);
    req1 = 0; mem_ready = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
